lt_aux_req_arbiter: RTL and testbench

Store-and-forward arbiter between the link-training FSMs (clock recovery and channel equalization) and the AUX control unit. It captures each source's streamed AUX request into a private 16-byte buffer, serializes the buffered requests onto a single AUX request port, and waits for the AUX control unit's reply. It then returns the ack/fail pulse only to the source that owns the transaction. It sits directly downstream of the CR/EQ link-training top and upstream of the AUX control unit.

---
 rtl/lt_aux_pkg.sv | 15 +
 rtl/lt_aux_req_buf.sv | 67 ++++++
 rtl/lt_aux_req_arbiter.sv | 152 +++++++++++++++
 tb/tb_lt_aux_req_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lt_aux_pkg.sv
// lt_aux_pkg: shared AUX command encodings, arbiter/buffer states and the request header
package lt_aux_pkg;
    localparam logic [1:0] AUX_NATIVE_WR = 2'b00;
    localparam logic [1:0] AUX_NATIVE_RD = 2'b01;
    localparam logic [1:0] AUX_I2C_WR    = 2'b10;
    localparam logic [1:0] AUX_I2C_RD    = 2'b11;
    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT_REPLY} arb_state_t;
    typedef enum logic {OWN_CR, OWN_EQ} owner_t;
    typedef enum logic [1:0] {BUF_EMPTY, BUF_CAPTURE, BUF_PENDING} buf_state_t;
    typedef struct packed {
        logic [1:0]  cmd;
        logic [19:0] address;
        logic [7:0]  len;
    } req_hdr_t;
endpackage

// File: rtl/lt_aux_req_buf.sv
// lt_aux_req_buf: captures one source's streamed AUX request, clips its length and flags drops
module lt_aux_req_buf
    import lt_aux_pkg::*;
#(
    parameter int BUF_DEPTH = 16,
    parameter int AW = $clog2(BUF_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vld,
    input  logic [1:0]    cmd,
    input  logic [19:0]   address,
    input  logic [7:0]    len,
    input  logic [7:0]    data,
    input  logic [AW-1:0] rd_idx,
    input  logic          free,
    output logic          pending,
    output req_hdr_t      hdr,
    output logic [7:0]    rd_data,
    output logic          drop
);
    localparam logic [7:0] LAST = 8'(BUF_DEPTH - 1);
    logic [7:0] mem [BUF_DEPTH];
    buf_state_t st;
    logic [7:0] idx;
    logic [7:0] raw_len;
    // pending covers both waiting-for-grant and in-flight; only the arbiter's free releases it
    assign pending = st == BUF_PENDING;
    assign rd_data = mem[rd_idx];
    // capture beats, discard overflow bytes, and pulse drop on clip, early end or busy beat
    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= BUF_EMPTY;
            idx     <= '0;
            raw_len <= '0;
            hdr     <= '0;
            drop    <= 1'b0;
        end else begin
            drop <= 1'b0;
            case (st)
                BUF_EMPTY: if (vld) begin
                    hdr     <= '{cmd: cmd, address: address,
                                 len: (!cmd[0] && len > LAST) ? LAST : len};
                    raw_len <= len;
                    mem['0] <= data;
                    idx     <= 8'd1;
                    st      <= (cmd[0] || len == 8'd0) ? BUF_PENDING : BUF_CAPTURE;
                end
                BUF_CAPTURE: if (!vld) begin
                    st   <= BUF_EMPTY;
                    drop <= 1'b1;
                end else begin
                    if (idx <= LAST) mem[idx[AW-1:0]] <= data;
                    idx <= idx + 8'd1;
                    if (idx == raw_len) begin
                        st   <= BUF_PENDING;
                        drop <= raw_len > LAST;
                    end
                end
                default: begin
                    drop <= vld;
                    if (free) st <= BUF_EMPTY;
                end
            endcase
        end
    end
endmodule

// File: rtl/lt_aux_req_arbiter.sv
// lt_aux_req_arbiter: serializes buffered CR/EQ AUX requests and routes replies to the owner
module lt_aux_req_arbiter
    import lt_aux_pkg::*;
#(
    parameter int BUF_DEPTH = 16,
    parameter int REPLY_TIMEOUT = 400
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cr_transaction_vld,
    input  logic [1:0]  cr_cmd,
    input  logic [19:0] cr_address,
    input  logic [7:0]  cr_len,
    input  logic [7:0]  cr_data,
    input  logic        eq_transaction_vld,
    input  logic [1:0]  eq_cmd,
    input  logic [19:0] eq_address,
    input  logic [7:0]  eq_len,
    input  logic [7:0]  eq_data,
    input  logic        ctrl_ack_flag,
    input  logic        ctrl_native_failed,
    output logic        lt_transaction_vld,
    output logic [1:0]  lt_cmd,
    output logic [19:0] lt_address,
    output logic [7:0]  lt_len,
    output logic [7:0]  lt_data,
    output logic        cr_ctrl_ack_flag,
    output logic        cr_ctrl_native_failed,
    output logic        eq_ctrl_ack_flag,
    output logic        eq_ctrl_native_failed,
    output logic        lt_req_drop
);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam int TW = $clog2(REPLY_TIMEOUT + 1);
    arb_state_t state, state_n;
    owner_t owner, owner_n, pick, src;
    logic [AW-1:0] beat, beat_n, rd_idx;
    logic [TW-1:0] tmo, tmo_n;
    logic cr_pending, eq_pending, cr_free, eq_free, cr_drop, eq_drop;
    req_hdr_t cr_hdr, eq_hdr, hdr;
    logic [7:0] cr_rd, eq_rd, rdd;
    logic vld_n, last, fail;
    logic [1:0] cmd_n;
    logic [19:0] addr_n;
    logic [7:0] len_n, data_n;
    logic cr_ack_n, cr_fail_n, eq_ack_n, eq_fail_n;

    lt_aux_req_buf #(.BUF_DEPTH(BUF_DEPTH)) u_cr_buf (
        .clk(clk), .rst(rst), .vld(cr_transaction_vld), .cmd(cr_cmd), .address(cr_address),
        .len(cr_len), .data(cr_data), .rd_idx(rd_idx), .free(cr_free),
        .pending(cr_pending), .hdr(cr_hdr), .rd_data(cr_rd), .drop(cr_drop)
    );
    lt_aux_req_buf #(.BUF_DEPTH(BUF_DEPTH)) u_eq_buf (
        .clk(clk), .rst(rst), .vld(eq_transaction_vld), .cmd(eq_cmd), .address(eq_address),
        .len(eq_len), .data(eq_data), .rd_idx(rd_idx), .free(eq_free),
        .pending(eq_pending), .hdr(eq_hdr), .rd_data(eq_rd), .drop(eq_drop)
    );

    // in IDLE the byte/header for a fresh grant is read combinationally so the first beat is registered directly
    assign pick        = cr_pending ? OWN_CR : OWN_EQ;
    assign src         = state == ST_IDLE ? pick : owner;
    assign hdr         = src == OWN_CR ? cr_hdr : eq_hdr;
    assign rdd         = src == OWN_CR ? cr_rd : eq_rd;
    assign rd_idx      = state == ST_SEND ? beat + 1'b1 : '0;
    assign last        = lt_cmd[0] || beat == lt_len[AW-1:0];
    assign fail        = ctrl_native_failed || tmo == TW'(REPLY_TIMEOUT);
    assign lt_req_drop = cr_drop | eq_drop;

    // next-state and next-output decode; replies outside WAIT_REPLY fall through to the defaults
    always_comb begin
        state_n   = state;
        owner_n   = owner;
        beat_n    = beat;
        tmo_n     = tmo;
        vld_n     = 1'b0;
        cmd_n     = lt_cmd;
        addr_n    = lt_address;
        len_n     = lt_len;
        data_n    = lt_data;
        cr_ack_n  = 1'b0;
        cr_fail_n = 1'b0;
        eq_ack_n  = 1'b0;
        eq_fail_n = 1'b0;
        cr_free   = 1'b0;
        eq_free   = 1'b0;
        case (state)
            ST_IDLE: if (cr_pending || eq_pending) begin
                state_n = ST_SEND;
                owner_n = pick;
                beat_n  = '0;
                vld_n   = 1'b1;
                cmd_n   = hdr.cmd;
                addr_n  = hdr.address;
                len_n   = hdr.len;
                data_n  = rdd;
            end
            ST_SEND: if (last) begin
                state_n = ST_WAIT_REPLY;
                tmo_n   = '0;
            end else begin
                vld_n  = 1'b1;
                beat_n = beat + 1'b1;
                data_n = rdd;
            end
            default: begin
                tmo_n = tmo == TW'(REPLY_TIMEOUT) ? tmo : tmo + 1'b1;
                if (fail || ctrl_ack_flag) begin
                    state_n   = ST_IDLE;
                    cr_free   = owner == OWN_CR;
                    eq_free   = owner == OWN_EQ;
                    cr_fail_n = fail && owner == OWN_CR;
                    eq_fail_n = fail && owner == OWN_EQ;
                    cr_ack_n  = !fail && owner == OWN_CR;
                    eq_ack_n  = !fail && owner == OWN_EQ;
                end
            end
        endcase
    end

    // state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= ST_IDLE;
            owner                 <= OWN_CR;
            beat                  <= '0;
            tmo                   <= '0;
            lt_transaction_vld    <= 1'b0;
            lt_cmd                <= '0;
            lt_address            <= '0;
            lt_len                <= '0;
            lt_data               <= '0;
            cr_ctrl_ack_flag      <= 1'b0;
            cr_ctrl_native_failed <= 1'b0;
            eq_ctrl_ack_flag      <= 1'b0;
            eq_ctrl_native_failed <= 1'b0;
        end else begin
            state                 <= state_n;
            owner                 <= owner_n;
            beat                  <= beat_n;
            tmo                   <= tmo_n;
            lt_transaction_vld    <= vld_n;
            lt_cmd                <= cmd_n;
            lt_address            <= addr_n;
            lt_len                <= len_n;
            lt_data               <= data_n;
            cr_ctrl_ack_flag      <= cr_ack_n;
            cr_ctrl_native_failed <= cr_fail_n;
            eq_ctrl_ack_flag      <= eq_ack_n;
            eq_ctrl_native_failed <= eq_fail_n;
        end
    end
endmodule

// File: tb/tb_lt_aux_req_arbiter.sv
// tb_lt_aux_req_arbiter: directed scoreboard bench for the CR/EQ AUX request arbiter
module tb_lt_aux_req_arbiter;
    import lt_aux_pkg::*;
    logic clk = 1'b0;
    logic rst;
    logic cr_transaction_vld, eq_transaction_vld, ctrl_ack_flag, ctrl_native_failed;
    logic [1:0] cr_cmd, eq_cmd, lt_cmd;
    logic [19:0] cr_address, eq_address, lt_address;
    logic [7:0] cr_len, eq_len, cr_data, eq_data, lt_len, lt_data;
    logic lt_transaction_vld, cr_ctrl_ack_flag, cr_ctrl_native_failed;
    logic eq_ctrl_ack_flag, eq_ctrl_native_failed, lt_req_drop;
    logic [43:0] outs;
    typedef struct {
        logic        rd;
        logic [1:0]  cmd;
        logic [19:0] addr;
        logic [7:0]  len;
        logic [7:0]  data;
    } beat_t;
    beat_t exp_q[$];
    int n_chk = 0, n_fail = 0, cyc = 0, beats = 0;
    int first_vld_cyc = -1, last_vld_cyc = -1;
    int cr_ack_n = 0, cr_fail_n = 0, eq_ack_n = 0, eq_fail_n = 0, drop_n = 0;
    int cr_ack_cyc = -1, cr_fail_cyc = -1, eq_ack_cyc = -1, eq_fail_cyc = -1;
    int d0, b0, f0, a0, s0, rc;
    logic prev_vld = 1'b0;

    always #5 clk = ~clk;

    lt_aux_req_arbiter dut (
        .clk(clk), .rst(rst),
        .cr_transaction_vld(cr_transaction_vld), .cr_cmd(cr_cmd), .cr_address(cr_address),
        .cr_len(cr_len), .cr_data(cr_data),
        .eq_transaction_vld(eq_transaction_vld), .eq_cmd(eq_cmd), .eq_address(eq_address),
        .eq_len(eq_len), .eq_data(eq_data),
        .ctrl_ack_flag(ctrl_ack_flag), .ctrl_native_failed(ctrl_native_failed),
        .lt_transaction_vld(lt_transaction_vld), .lt_cmd(lt_cmd), .lt_address(lt_address),
        .lt_len(lt_len), .lt_data(lt_data),
        .cr_ctrl_ack_flag(cr_ctrl_ack_flag), .cr_ctrl_native_failed(cr_ctrl_native_failed),
        .eq_ctrl_ack_flag(eq_ctrl_ack_flag), .eq_ctrl_native_failed(eq_ctrl_native_failed),
        .lt_req_drop(lt_req_drop)
    );

    assign outs = {lt_transaction_vld, lt_cmd, lt_address, lt_len, lt_data, cr_ctrl_ack_flag,
                   cr_ctrl_native_failed, eq_ctrl_ack_flag, eq_ctrl_native_failed, lt_req_drop};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] dat(input int i);
        return 8'(i * 7 + 33);
    endfunction

    // advance one clock, sample 1 time unit after the edge, pop scoreboard on every lt beat
    task automatic tick();
        beat_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (lt_transaction_vld) begin
            beats++;
            if (!prev_vld) first_vld_cyc = cyc;
            last_vld_cyc = cyc;
            if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("beat", {lt_cmd, lt_address, lt_len, e.rd ? 8'h00 : lt_data},
                    {e.cmd, e.addr, e.len, e.rd ? 8'h00 : e.data});
            end
        end
        prev_vld = lt_transaction_vld;
        drop_n += int'(lt_req_drop);
        if (cr_ctrl_ack_flag) begin cr_ack_n++; cr_ack_cyc = cyc; end
        if (cr_ctrl_native_failed) begin cr_fail_n++; cr_fail_cyc = cyc; end
        if (eq_ctrl_ack_flag) begin eq_ack_n++; eq_ack_cyc = cyc; end
        if (eq_ctrl_native_failed) begin eq_fail_n++; eq_fail_cyc = cyc; end
    endtask

    task automatic settle(input int n);
        repeat (n) tick();
    endtask

    task automatic drive(input bit eq, input logic v, input logic [1:0] c, input logic [19:0] a,
                         input logic [7:0] l, input logic [7:0] d);
        if (eq) begin
            eq_transaction_vld = v; eq_cmd = c; eq_address = a; eq_len = l; eq_data = d;
        end else begin
            cr_transaction_vld = v; cr_cmd = c; cr_address = a; cr_len = l; cr_data = d;
        end
    endtask

    task automatic idle_src();
        drive(0, 0, 2'b00, 20'h0, 8'h0, 8'h0);
        drive(1, 0, 2'b00, 20'h0, 8'h0, 8'h0);
    endtask

    task automatic push(input logic rd, input logic [1:0] c, input logic [19:0] a,
                        input logic [7:0] l, input logic [7:0] d);
        beat_t e;
        e = '{rd, c, a, l, d};
        exp_q.push_back(e);
    endtask

    // streams nbeats write bytes; only a complete request is expected on the lt port
    task automatic send_write(input bit eq, input logic [19:0] a, input logic [7:0] l, input int nbeats);
        int top;
        top = (l > 8'd15) ? 15 : int'(l);
        if (nbeats == int'(l) + 1)
            for (int i = 0; i <= top; i++) push(0, AUX_NATIVE_WR, a, 8'(top), dat(i));
        for (int i = 0; i < nbeats; i++) begin
            drive(eq, 1, AUX_NATIVE_WR, a, l, dat(i));
            tick();
        end
        idle_src();
    endtask

    task automatic send_read(input bit eq, input logic [19:0] a, input logic [7:0] l);
        push(1, AUX_NATIVE_RD, a, l, 8'h00);
        drive(eq, 1, AUX_NATIVE_RD, a, l, 8'h5a);
        tick();
        idle_src();
    endtask

    task automatic drain();
        int k = 0;
        while ((exp_q.size() != 0 || lt_transaction_vld) && k < 200) begin
            tick();
            k++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic reply(input logic a, input logic f);
        ctrl_ack_flag = a;
        ctrl_native_failed = f;
        tick();
        ctrl_ack_flag = 0;
        ctrl_native_failed = 0;
    endtask

    initial begin
        int k;
        rst = 1;
        ctrl_ack_flag = 0;
        ctrl_native_failed = 0;
        idle_src();
        settle(2);
        chk("reset_outputs", outs, 0);
        rst = 0;
        settle(2);

        // CR single-byte native write, acked later
        send_write(0, 20'h00102, 8'd0, 1);
        tick();
        chk("cr_wr_latency", first_vld_cyc, cyc);
        drain();
        settle(9);
        reply(1, 0);
        rc = cyc;
        chk("cr_ack_cyc", cr_ack_cyc, rc);
        settle(3);
        chk("cr_ack_count", cr_ack_n, 1);
        chk("others_quiet", eq_ack_n + eq_fail_n + cr_fail_n, 0);

        // EQ native read len 5, NACKed
        first_vld_cyc = -1;
        send_read(1, 20'h00202, 8'd5);
        tick();
        chk("eq_rd_latency", first_vld_cyc, cyc);
        drain();
        settle(3);
        reply(0, 1);
        chk("eq_fail_cyc", eq_fail_cyc, cyc);
        settle(2);
        chk("eq_fail_count", eq_fail_n, 1);
        chk("cr_unchanged", cr_ack_n * 16 + cr_fail_n, 16);

        // CR 4-byte write and EQ read finishing together: CR first, EQ after CR reply
        for (int i = 0; i < 4; i++) push(0, AUX_NATIVE_WR, 20'h00300, 8'd3, dat(i));
        push(1, AUX_NATIVE_RD, 20'h00400, 8'd0, 8'h00);
        first_vld_cyc = -1;
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, AUX_NATIVE_WR, 20'h00300, 8'd3, dat(i));
            if (i == 3) drive(1, 1, AUX_NATIVE_RD, 20'h00400, 8'd0, 8'h00);
            tick();
        end
        idle_src();
        tick();
        chk("cr_first_latency", first_vld_cyc, cyc);
        k = 0;
        while ((exp_q.size() != 1 || lt_transaction_vld) && k < 50) begin tick(); k++; end
        chk("cr_beats_done", exp_q.size(), 1);
        settle(5);
        chk("eq_held", exp_q.size(), 1);
        first_vld_cyc = -1;
        reply(1, 0);
        rc = cyc;
        tick();
        chk("eq_after_reply", first_vld_cyc, rc + 1);
        drain();
        reply(1, 0);
        chk("eq_ack_count", eq_ack_n, 1);
        chk("cr_ack_count2", cr_ack_n, 2);

        // overlong write is clipped to 16 gapless beats with a drop pulse
        d0 = drop_n;
        first_vld_cyc = -1;
        send_write(0, 20'h00500, 8'd20, 21);
        tick();
        chk("clip_latency", first_vld_cyc, cyc);
        drain();
        chk("clip_gapless", last_vld_cyc - first_vld_cyc, 15);
        chk("clip_drop", drop_n, d0 + 1);
        reply(1, 0);
        settle(1);

        // vld falls after 2 of 4 beats: discarded
        d0 = drop_n;
        b0 = beats;
        send_write(0, 20'h00600, 8'd3, 2);
        settle(6);
        chk("early_drop", drop_n, d0 + 1);
        chk("early_nothing", beats, b0);

        // busy beat dropped, then reply timeout, then late ack ignored
        first_vld_cyc = -1;
        send_read(0, 20'h00700, 8'd0);
        tick();
        chk("tmo_rd_latency", first_vld_cyc, cyc);
        drain();
        d0 = drop_n;
        b0 = beats;
        drive(0, 1, AUX_NATIVE_RD, 20'h00701, 8'd0, 8'h00);
        tick();
        idle_src();
        settle(1);
        chk("busy_drop", drop_n, d0 + 1);
        f0 = cr_fail_n;
        a0 = cr_ack_n;
        k = 0;
        while (cr_fail_n == f0 && k < 600) begin tick(); k++; end
        chk("tmo_fail", cr_fail_n, f0 + 1);
        chk("tmo_window", (cr_fail_cyc - first_vld_cyc >= 400 && cr_fail_cyc - first_vld_cyc <= 404), 1);
        reply(1, 0);
        settle(2);
        chk("late_ack_ignored", cr_ack_n * 16 + eq_ack_n, a0 * 16 + 1);
        chk("busy_not_sent", beats, b0);
        first_vld_cyc = -1;
        send_read(1, 20'h00800, 8'd2);
        tick();
        chk("idle_after_tmo", first_vld_cyc, cyc);
        drain();
        reply(1, 0);
        chk("eq_ack_count2", eq_ack_n, 2);

        // reset in the middle of a SEND
        send_write(0, 20'h00900, 8'd7, 8);
        b0 = beats;
        k = 0;
        while (beats < b0 + 3 && k < 50) begin tick(); k++; end
        chk("mid_send_reached", beats, b0 + 3);
        rst = 1;
        tick();
        exp_q.delete();
        chk("reset_mid_send", outs, 0);
        rst = 0;
        b0 = beats;
        s0 = cr_ack_n + cr_fail_n + eq_ack_n + eq_fail_n;
        reply(1, 0);
        reply(0, 1);
        settle(3);
        chk("no_reply_after_rst", cr_ack_n + cr_fail_n + eq_ack_n + eq_fail_n, s0);
        chk("no_beats_after_rst", beats, b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
